// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-write-side signals of the round-robin FIFO write arbiter.
// The master modport belongs to the arbiter. The slave modport belongs to the producers and the FIFO.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  // Handshake: req[i] is producer i's valid and req_ack[i] is its ready/accept.
  // A beat moves on a rising edge where req[i] & req_ack[i] are both high.
  // req_data/req_last must stay stable while req[i] is high and not yet acked.
  // fifo_write is asserted only when fifo_full is low.
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ack;
  logic                          fifo_full;
  logic                          fifo_write;
  logic [DATA_WIDTH-1:0]         fifo_datain;
  logic [GW-1:0]                 grant_id;
  logic                          busy;
  logic                          dbg_state;
  logic [GW-1:0]                 dbg_rr_ptr;
  logic [CW-1:0]                 dbg_beat_cnt;

  modport master (
    input  req, req_data, req_last, fifo_full,
    output req_ack, fifo_write, fifo_datain, grant_id, busy,
           dbg_state, dbg_rr_ptr, dbg_beat_cnt
  );

  modport slave (
    output req, req_data, req_last, fifo_full,
    input  req_ack, fifo_write, fifo_datain, grant_id, busy,
           dbg_state, dbg_rr_ptr, dbg_beat_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one ring-FIFO write port among NUM_REQ producers.
// Each grant covers a burst of beats. A grant ends on last, on MAX_BURST beats, or when the producer aborts.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input logic              clk,
  input logic              reset,
  fifo_wr_arbiter_if.master bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_rr_ptr;
  logic [GW-1:0]   r_grant_id;
  logic [CW-1:0]   r_beat_cnt;

  logic                  w_pick_valid;
  logic [GW-1:0]         w_pick_id;
  logic [GW-1:0]         w_scan_idx;
  logic                  w_req_g;
  logic                  w_last_g;
  logic [DATA_WIDTH-1:0] w_data_g;
  logic                  w_granted;
  logic                  w_beat;
  logic                  w_cnt_max;
  logic                  w_exit;
  logic [GW-1:0]         w_next_ptr;
  logic [NUM_REQ-1:0]    w_ack;

  // Scan downward so the requester closest to r_rr_ptr is the last one written.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick_id    = '0;
    w_scan_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_scan_idx = GW'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (bus.req[w_scan_idx]) begin
        w_pick_valid = 1'b1;
        w_pick_id    = w_scan_idx;
      end
    end
  end

  always_comb begin
    w_req_g  = 1'b0;
    w_last_g = 1'b0;
    w_data_g = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == GW'(i)) begin
        w_req_g  = bus.req[i];
        w_last_g = bus.req_last[i];
        w_data_g = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_granted  = (r_state == S_GRANT);
  assign w_beat     = w_granted & w_req_g & ~bus.fifo_full;
  assign w_cnt_max  = (r_beat_cnt == CW'(MAX_BURST - 1));
  assign w_exit     = w_granted & (~w_req_g | (w_beat & (w_last_g | w_cnt_max)));
  assign w_next_ptr = (r_grant_id == GW'(NUM_REQ - 1)) ? '0 : r_grant_id + GW'(1);

  always_comb begin
    w_ack = '0;
    if (w_beat) w_ack[r_grant_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_valid) begin
            r_grant_id <= w_pick_id;
            r_beat_cnt <= '0;
            r_state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          // A stalled cycle (fifo_full) keeps the grant and leaves the count unchanged.
          if (w_exit) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= w_next_ptr;
            r_beat_cnt <= '0;
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.fifo_write   = w_beat;
  assign bus.req_ack      = w_ack;
  assign bus.fifo_datain  = w_granted ? w_data_g : '0;
  assign bus.grant_id     = r_grant_id;
  assign bus.busy         = w_granted;
  assign bus.dbg_state    = r_state;
  assign bus.dbg_rr_ptr   = r_rr_ptr;
  assign bus.dbg_beat_cnt = r_beat_cnt;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random bench for fifo_wr_arbiter.
// A cycle-level reference model plus a write-data scoreboard check every output.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) bus();

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  int grant_log[$];
  logic [DW-1:0] exp_q[$];

  // Reference state: whether a burst is active, who owns it, next scan start, beats so far.
  bit m_busy;
  int m_gid;
  int m_ptr;
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_gid  = 0;
    m_ptr  = 0;
    m_cnt  = 0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = DW'($urandom);
  endtask

  // Check the current cycle and advance the model across the next rising edge.
  // End on the following falling edge.
  task automatic step();
    bit            e_beat;
    logic [N-1:0]  e_ack;
    logic [DW-1:0] e_data;
    logic [DW-1:0] popped;
    bit            found;
    int            idx;
    #1;
    e_beat = m_busy && bus.req[m_gid] && !bus.fifo_full;
    e_ack  = '0;
    if (e_beat) e_ack[m_gid] = 1'b1;
    e_data = m_busy ? bus.req_data[m_gid*DW +: DW] : '0;
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("fifo_write", 32'(bus.fifo_write), 32'(e_beat));
    chk("req_ack", 32'(bus.req_ack), 32'(e_ack));
    chk("fifo_datain", 32'(bus.fifo_datain), 32'(e_data));
    chk("grant_id", 32'(bus.grant_id), m_gid);
    chk("rr_ptr", 32'(bus.dbg_rr_ptr), m_ptr);
    if (m_busy) chk("beat_cnt", 32'(bus.dbg_beat_cnt), m_cnt);
    if (e_beat) exp_q.push_back(e_data);
    if (bus.fifo_write === 1'b1) begin
      n_writes++;
      grant_log.push_back(int'(bus.grant_id));
      chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        popped = exp_q.pop_front();
        chk("sb_data", 32'(bus.fifo_datain), 32'(popped));
      end
    end
    if (!m_busy) begin
      found = 1'b0;
      for (int d = 0; d < N; d++) begin
        idx = (m_ptr + d) % N;
        if (!found && bus.req[idx]) begin
          found = 1'b1;
          m_gid = idx;
        end
      end
      if (found) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else if (!bus.req[m_gid] || (e_beat && (bus.req_last[m_gid] || m_cnt == MB - 1))) begin
      m_busy = 1'b0;
      m_ptr  = (m_gid + 1) % N;
    end else if (e_beat) begin
      m_cnt++;
    end
    @(negedge clk);
  endtask

  // Assert reset between edges and check that the outputs clear without waiting for a clock.
  task automatic do_reset();
    chk("sb_drain", exp_q.size(), 0);
    #3 reset = 1'b0;
    #1;
    chk("rst_write", 32'(bus.fifo_write), 0);
    chk("rst_ack", 32'(bus.req_ack), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_datain", 32'(bus.fifo_datain), 0);
    chk("rst_grant", 32'(bus.grant_id), 0);
    model_reset();
    @(negedge clk);
    bus.req       = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  int order[5] = '{0, 1, 2, 3, 0};

  initial begin
    bus.req       = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("init_busy", 32'(bus.busy), 0);
    chk("init_write", 32'(bus.fifo_write), 0);
    chk("init_ack", 32'(bus.req_ack), 0);
    chk("init_datain", 32'(bus.fifo_datain), 0);
    chk("init_grant", 32'(bus.grant_id), 0);
    chk("init_ptr", 32'(bus.dbg_rr_ptr), 0);
    @(negedge clk);
    reset = 1'b1;

    // Test 1: requester 2 alone sends a three-beat burst.
    n_writes = 0;
    bus.req = 4'b0100;
    rand_data();
    step();
    chk("t1_grant", 32'(bus.grant_id), 2);
    repeat (2) begin rand_data(); step(); end
    bus.req_last = 4'b0100;
    rand_data();
    step();
    bus.req = '0;
    bus.req_last = '0;
    step();
    chk("t1_writes", n_writes, 3);
    chk("t1_ptr", 32'(bus.dbg_rr_ptr), 3);

    // Test 2: all requesters active with single-beat bursts.
    do_reset();
    grant_log.delete();
    bus.req = 4'b1111;
    bus.req_last = 4'b1111;
    repeat (10) begin rand_data(); step(); end
    chk("t2_count", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("t2_order", grant_log[i], order[i]);

    // Test 3: requester 1 never sets last, so the burst is forced to release after MAX_BURST beats.
    do_reset();
    n_writes = 0;
    bus.req = 4'b0010;
    repeat (9) begin rand_data(); step(); end
    chk("t3_burst_len", n_writes, MB);
    bus.req = 4'b1010;
    rand_data();
    step();
    chk("t3_next_grant", 32'(bus.grant_id), 3);
    bus.req_last = 4'b1000;
    repeat (3) begin rand_data(); step(); end
    bus.req = 4'b0010;
    bus.req_last = '0;
    repeat (3) begin rand_data(); step(); end
    chk("t3_regrant", 32'(bus.grant_id), 1);

    // Test 4: the FIFO reports full for five cycles in the middle of a burst.
    do_reset();
    bus.req = 4'b0001;
    repeat (3) begin rand_data(); step(); end
    bus.fifo_full = 1'b1;
    repeat (5) begin rand_data(); step(); end
    chk("t4_cnt_frozen", 32'(bus.dbg_beat_cnt), 2);
    chk("t4_grant_kept", 32'(bus.busy), 1);
    bus.fifo_full = 1'b0;
    repeat (2) begin rand_data(); step(); end
    bus.req_last = 4'b0001;
    step();
    bus.req = '0;
    bus.req_last = '0;
    step();

    // Test 5: requester 0 drops req in the middle of a burst.
    do_reset();
    bus.req = 4'b0001;
    repeat (2) begin rand_data(); step(); end
    bus.req = '0;
    step();
    step();
    chk("t5_ptr", 32'(bus.dbg_rr_ptr), 1);

    // Test 6: reset is asserted in the middle of a burst.
    do_reset();
    bus.req = 4'b0100;
    repeat (3) begin rand_data(); step(); end
    do_reset();
    step();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        bus.req[i]      = ($urandom_range(0, 9) < 7);
        bus.req_last[i] = ($urandom_range(0, 9) < 3);
      end
      bus.fifo_full = ($urandom_range(0, 9) < 2);
      rand_data();
      step();
    end
    bus.req = '0;
    bus.req_last = '0;
    bus.fifo_full = 1'b0;
    repeat (2) step();
    chk("final_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
